// File: rtl/regfile_arbiter.sv
// regfile_arbiter: serialises two valid/ready requesters onto the single
// WrEn/RdEn/Address/WrData port of the 8x16 register file and routes the
// registered read data back to the port that issued the read.
// Build option: define REGFILE_ARB_ROUND_ROBIN_EN for round-robin
// arbitration; otherwise port 0 has fixed priority.
module regfile_arbiter (
    input  logic        CLK,
    input  logic        RST,
    // port 0
    input  logic        REQ0_Valid,
    output logic        REQ0_Ready,
    input  logic        REQ0_Wr,
    input  logic [2:0]  REQ0_Addr,
    input  logic [15:0] REQ0_WrData,
    output logic        RSP0_Valid,
    output logic [15:0] RSP0_RdData,
    // port 1
    input  logic        REQ1_Valid,
    output logic        REQ1_Ready,
    input  logic        REQ1_Wr,
    input  logic [2:0]  REQ1_Addr,
    input  logic [15:0] REQ1_WrData,
    output logic        RSP1_Valid,
    output logic [15:0] RSP1_RdData,
    // register file side
    output logic        RF_WrEn,
    output logic        RF_RdEn,
    output logic [2:0]  RF_Address,
    output logic [15:0] RF_WrData,
    input  logic [15:0] RF_RdData,
    output logic        Busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, RDWAIT} state_t;

    typedef struct packed {
        logic        wr;
        logic [2:0]  addr;
        logic [15:0] wdata;
        logic        port;
    } cmd_t;

    state_t state, state_nxt;
    cmd_t   cmd, cmd_sel;
    logic   gnt_port;   // 0 = port 0 wins, 1 = port 1 wins
    logic   accept;

`ifdef REGFILE_ARB_ROUND_ROBIN_EN
    logic last_grant;

    // Round-robin: on contention the port not granted last wins
    always_comb begin
        if (REQ0_Valid && REQ1_Valid)
            gnt_port = ~last_grant;
        else
            gnt_port = ~REQ0_Valid;
    end

    // Pointer follows every grant; resets to 1 so port 0 wins first
    always_ff @(posedge CLK) begin
        if (RST)
            last_grant <= 1'b1;
        else if (accept)
            last_grant <= gnt_port;
    end
`else
    // Fixed priority: port 1 only when port 0 is idle
    always_comb begin
        gnt_port = ~REQ0_Valid;
    end
`endif

    // Handshake and selection of the winning command
    always_comb begin
        accept     = (state == IDLE) && !RST && (REQ0_Valid || REQ1_Valid);
        REQ0_Ready = accept && !gnt_port;
        REQ1_Ready = accept &&  gnt_port;
        if (gnt_port)
            cmd_sel = '{wr: REQ1_Wr, addr: REQ1_Addr, wdata: REQ1_WrData, port: 1'b1};
        else
            cmd_sel = '{wr: REQ0_Wr, addr: REQ0_Addr, wdata: REQ0_WrData, port: 1'b0};
    end

    // Next state and register-file port drive; RF lines are 0 outside ACCESS
    always_comb begin
        state_nxt  = state;
        RF_WrEn    = 1'b0;
        RF_RdEn    = 1'b0;
        RF_Address = '0;
        RF_WrData  = '0;
        case (state)
            IDLE: begin
                if (accept)
                    state_nxt = ACCESS;
            end
            ACCESS: begin
                RF_Address = cmd.addr;
                RF_WrData  = cmd.wdata;
                RF_WrEn    = cmd.wr;
                RF_RdEn    = !cmd.wr;
                state_nxt  = cmd.wr ? IDLE : RDWAIT;
            end
            RDWAIT: begin
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign Busy = (state != IDLE);

    // State, command latch and read-response capture; reset drops any
    // read in flight without a response pulse
    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= IDLE;
            cmd         <= '0;
            RSP0_Valid  <= 1'b0;
            RSP1_Valid  <= 1'b0;
            RSP0_RdData <= '0;
            RSP1_RdData <= '0;
        end else begin
            state      <= state_nxt;
            RSP0_Valid <= 1'b0;
            RSP1_Valid <= 1'b0;
            if (accept)
                cmd <= cmd_sel;
            if (state == RDWAIT) begin
                if (cmd.port) begin
                    RSP1_Valid  <= 1'b1;
                    RSP1_RdData <= RF_RdData;
                end else begin
                    RSP0_Valid  <= 1'b1;
                    RSP0_RdData <= RF_RdData;
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_arbiter.sv
// Directed bench for regfile_arbiter with a behavioural 8x16 register file
// (registered read). Contention expectations follow the arbitration build
// option REGFILE_ARB_ROUND_ROBIN_EN.
module tb_regfile_arbiter;

    logic        CLK = 1'b0;
    logic        RST;
    logic        REQ0_Valid, REQ0_Ready, REQ0_Wr;
    logic [2:0]  REQ0_Addr;
    logic [15:0] REQ0_WrData;
    logic        RSP0_Valid;
    logic [15:0] RSP0_RdData;
    logic        REQ1_Valid, REQ1_Ready, REQ1_Wr;
    logic [2:0]  REQ1_Addr;
    logic [15:0] REQ1_WrData;
    logic        RSP1_Valid;
    logic [15:0] RSP1_RdData;
    logic        RF_WrEn, RF_RdEn;
    logic [2:0]  RF_Address;
    logic [15:0] RF_WrData, RF_RdData;
    logic        Busy;

    int checks = 0;
    int errors = 0;

    logic [15:0] mem [8];

    regfile_arbiter dut (
        .CLK(CLK), .RST(RST),
        .REQ0_Valid(REQ0_Valid), .REQ0_Ready(REQ0_Ready), .REQ0_Wr(REQ0_Wr),
        .REQ0_Addr(REQ0_Addr), .REQ0_WrData(REQ0_WrData),
        .RSP0_Valid(RSP0_Valid), .RSP0_RdData(RSP0_RdData),
        .REQ1_Valid(REQ1_Valid), .REQ1_Ready(REQ1_Ready), .REQ1_Wr(REQ1_Wr),
        .REQ1_Addr(REQ1_Addr), .REQ1_WrData(REQ1_WrData),
        .RSP1_Valid(RSP1_Valid), .RSP1_RdData(RSP1_RdData),
        .RF_WrEn(RF_WrEn), .RF_RdEn(RF_RdEn), .RF_Address(RF_Address),
        .RF_WrData(RF_WrData), .RF_RdData(RF_RdData), .Busy(Busy)
    );

    always #5 CLK = ~CLK;

    // Register file model: synchronous write, registered read
    always @(posedge CLK) begin
        if (RF_WrEn) mem[RF_Address] <= RF_WrData;
        if (RF_RdEn) RF_RdData <= mem[RF_Address];
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int p, input logic v, input logic wr,
                           input logic [2:0] a, input logic [15:0] d);
        if (p == 0) begin
            REQ0_Valid = v; REQ0_Wr = wr; REQ0_Addr = a; REQ0_WrData = d;
        end else begin
            REQ1_Valid = v; REQ1_Wr = wr; REQ1_Addr = a; REQ1_WrData = d;
        end
    endtask

    // Full write transaction starting in an IDLE cycle; ends in next IDLE
    task automatic do_write(input int p, input logic [2:0] a, input logic [15:0] d);
        set_req(p, 1'b1, 1'b1, a, d);
        #1;
        chk("wr_ready", (p == 0) ? REQ0_Ready : REQ1_Ready, 16'd1);
        tick();
        set_req(p, 1'b0, 1'b0, 3'd0, 16'h0);
        tick();
    endtask

    initial begin
        logic exp1;
        for (int i = 0; i < 8; i++) mem[i] = 16'h0;
        RF_RdData = 16'h0;
        RST = 1'b1;
        set_req(0, 1'b0, 1'b0, 3'd0, 16'h0);
        set_req(1, 1'b0, 1'b0, 3'd0, 16'h0);
        tick();
        tick();

        // Ready forced low while reset is held
        REQ0_Valid = 1'b1; REQ1_Valid = 1'b1;
        #1;
        chk("rst_ready0", REQ0_Ready, 16'd0);
        chk("rst_ready1", REQ1_Ready, 16'd0);
        REQ0_Valid = 1'b0; REQ1_Valid = 1'b0;
        RST = 1'b0;
        tick();

        // Idle after reset: every output zero
        chk("idle_strobes", {9'd0, RF_WrEn, RF_RdEn, Busy, RSP0_Valid, RSP1_Valid,
                             REQ0_Ready, REQ1_Ready}, 16'd0);
        chk("idle_addr", {13'd0, RF_Address}, 16'd0);
        chk("idle_wdata", RF_WrData, 16'd0);
        chk("idle_rsp0", RSP0_RdData, 16'd0);
        chk("idle_rsp1", RSP1_RdData, 16'd0);

        // Single write: port 0, 16'hA5C3 to address 5
        set_req(0, 1'b1, 1'b1, 3'd5, 16'hA5C3);
        #1;
        chk("w_ready0", REQ0_Ready, 16'd1);
        chk("w_ready1", REQ1_Ready, 16'd0);
        tick();
        set_req(0, 1'b0, 1'b0, 3'd0, 16'h0);
        #1;
        chk("w_wren", RF_WrEn, 16'd1);
        chk("w_rden", RF_RdEn, 16'd0);
        chk("w_addr", {13'd0, RF_Address}, 16'd5);
        chk("w_wdata", RF_WrData, 16'hA5C3);
        chk("w_busy", Busy, 16'd1);
        tick();
        chk("w_done_busy", Busy, 16'd0);
        chk("w_done_wren", RF_WrEn, 16'd0);
        chk("w_done_wdata", RF_WrData, 16'd0);

        // Single read back: response at T+3
        set_req(0, 1'b1, 1'b0, 3'd5, 16'h0);
        #1;
        chk("r_ready0", REQ0_Ready, 16'd1);
        tick();
        set_req(0, 1'b0, 1'b0, 3'd0, 16'h0);
        #1;
        chk("r_rden", RF_RdEn, 16'd1);
        chk("r_wren", RF_WrEn, 16'd0);
        chk("r_addr", {13'd0, RF_Address}, 16'd5);
        tick();
        chk("r_wait_busy", Busy, 16'd1);
        chk("r_wait_rsp0", RSP0_Valid, 16'd0);
        chk("r_wait_rden", RF_RdEn, 16'd0);
        tick();
        chk("r_rsp0_valid", RSP0_Valid, 16'd1);
        chk("r_rsp0_data", RSP0_RdData, 16'hA5C3);
        chk("r_rsp1_valid", RSP1_Valid, 16'd0);
        chk("r_rsp_busy", Busy, 16'd0);
        tick();
        chk("r_pulse_end", RSP0_Valid, 16'd0);
        chk("r_data_held", RSP0_RdData, 16'hA5C3);

        // Cross-port ordering: port 1 writes BEEF to 3, port 0 reads 3
        set_req(1, 1'b1, 1'b1, 3'd3, 16'hBEEF);
        #1;
        chk("x_ready1", REQ1_Ready, 16'd1);
        chk("x_ready0", REQ0_Ready, 16'd0);
        tick();
        set_req(1, 1'b0, 1'b0, 3'd0, 16'h0);
        set_req(0, 1'b1, 1'b0, 3'd3, 16'h0);
        #1;
        chk("x_noready_access", REQ0_Ready, 16'd0);
        tick();
        chk("x_ready0_t2", REQ0_Ready, 16'd1);
        tick();
        set_req(0, 1'b0, 1'b0, 3'd0, 16'h0);
        tick();
        tick();
        chk("x_rsp0_valid", RSP0_Valid, 16'd1);
        chk("x_rsp0_data", RSP0_RdData, 16'hBEEF);

        // Preload contention data
        do_write(0, 3'd2, 16'h1111);
        do_write(1, 3'd6, 16'h2222);

        // Withdrawn request: port 1 valid only while busy
        set_req(0, 1'b1, 1'b0, 3'd2, 16'h0);
        #1;
        chk("wd_ready0", REQ0_Ready, 16'd1);
        tick();
        set_req(0, 1'b0, 1'b0, 3'd0, 16'h0);
        set_req(1, 1'b1, 1'b0, 3'd6, 16'h0);
        #1;
        chk("wd_ready1_access", REQ1_Ready, 16'd0);
        tick();
        chk("wd_ready1_rdwait", REQ1_Ready, 16'd0);
        set_req(1, 1'b0, 1'b0, 3'd0, 16'h0);
        tick();
        chk("wd_rsp0_data", RSP0_RdData, 16'h1111);
        chk("wd_ready1_idle", REQ1_Ready, 16'd0);
        chk("wd_busy_idle", Busy, 16'd0);
        tick();
        chk("wd_no_strobe", {14'd0, RF_RdEn, RF_WrEn}, 16'd0);
        chk("wd_no_busy", Busy, 16'd0);
        tick();
        chk("wd_no_rsp1", RSP1_Valid, 16'd0);

        // Mid-read reset: RST during RDWAIT discards the response
        set_req(0, 1'b1, 1'b0, 3'd6, 16'h0);
        #1;
        chk("mr_ready0", REQ0_Ready, 16'd1);
        tick();
        set_req(0, 1'b0, 1'b0, 3'd0, 16'h0);
        tick();
        chk("mr_rdwait", Busy, 16'd1);
        RST = 1'b1;
        tick();
        chk("mr_busy", Busy, 16'd0);
        chk("mr_rsp0", RSP0_Valid, 16'd0);
        chk("mr_rsp0_data", RSP0_RdData, 16'd0);
        RST = 1'b0;
        tick();
        chk("mr_rsp0_after", RSP0_Valid, 16'd0);
        chk("mr_busy_after", Busy, 16'd0);

        // Contention: both ports hold reads (port 0 addr 2, port 1 addr 6)
        set_req(0, 1'b1, 1'b0, 3'd2, 16'h0);
        set_req(1, 1'b1, 1'b0, 3'd6, 16'h0);
        for (int k = 0; k < 4; k++) begin
`ifdef REGFILE_ARB_ROUND_ROBIN_EN
            exp1 = (k % 2) == 1;
`else
            exp1 = 1'b0;
`endif
            #1;
            chk($sformatf("c_ready0_%0d", k), REQ0_Ready, {15'd0, !exp1});
            chk($sformatf("c_ready1_%0d", k), REQ1_Ready, {15'd0, exp1});
            tick();
            tick();
            tick();
            chk($sformatf("c_rsp0v_%0d", k), RSP0_Valid, {15'd0, !exp1});
            chk($sformatf("c_rsp1v_%0d", k), RSP1_Valid, {15'd0, exp1});
            if (exp1)
                chk($sformatf("c_rsp1d_%0d", k), RSP1_RdData, 16'h2222);
            else
                chk($sformatf("c_rsp0d_%0d", k), RSP0_RdData, 16'h1111);
        end

        // Port 0 drops: port 1 wins in this very IDLE cycle
        REQ0_Valid = 1'b0;
        #1;
        chk("c_drop_ready1", REQ1_Ready, 16'd1);
        chk("c_drop_ready0", REQ0_Ready, 16'd0);
        tick();
        set_req(1, 1'b0, 1'b0, 3'd0, 16'h0);
        tick();
        tick();
        chk("c_drop_rsp1v", RSP1_Valid, 16'd1);
        chk("c_drop_rsp1d", RSP1_RdData, 16'h2222);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_arbiter.md
# regfile_arbiter

Two-port arbiter and sequencer for the 8x16 register file. Accepts independent read/write requests from two requesters over valid/ready handshakes and serialises them onto the register file's single WrEn/RdEn/Address/WrData port. It then captures the registered RdData and returns it to the requester that issued the read. Sits between the control units (port 0, port 1) and the register file instance.

## Interface
- No parameters. Data width is 16 and address width is 3, fixed to match the register file.
- CLK  in  1  single clock for the block and the register file.
- RST  in  1  reset; synchronous, active-high.
- REQ0_Valid  in  1  port 0 request present.
- REQ0_Ready  out  1  port 0 request accepted this cycle.
- REQ0_Wr  in  1  1 = write, 0 = read.
- REQ0_Addr  in  3  register index.
- REQ0_WrData  in  16  write data.
- RSP0_Valid  out  1  one-cycle pulse when RSP0_RdData holds read result.
- RSP0_RdData  out  16  read result, held until the next port 0 read response.
- REQ1_* / RSP1_*  same set as port 0, for port 1.
- RF_WrEn  out  1  register file write strobe.
- RF_RdEn  out  1  register file read strobe.
- RF_Address  out  3  register file address.
- RF_WrData  out  16  register file write data.
- RF_RdData  in  16  register file output. It is registered inside the file, so it is valid the cycle after RF_RdEn.
- Busy  out  1  high whenever the FSM is not in IDLE.

## Operation
- FSM states are IDLE, ACCESS and RDWAIT.
- IDLE:
  - If any REQn_Valid is high, select a winner. Assert REQn_Ready for the winner only (combinational).
  - Latch its Wr/Addr/WrData and port id into command registers, then go to ACCESS.
  - With no request pending, stay in IDLE.
- ACCESS: drive RF_Address and RF_WrData from the command registers.
  - Write: RF_WrEn=1, RF_RdEn=0; return to IDLE.
  - Read: RF_RdEn=1, RF_WrEn=0; go to RDWAIT.
- RDWAIT:
  - Sample RF_RdData into RSPn_RdData of the latched port.
  - Set RSPn_Valid for the following cycle; return to IDLE.
- RF_WrEn and RF_RdEn are never high together, and each is high only in ACCESS.
- RF_Address and RF_WrData are 0 outside ACCESS.
- Requesters hold Valid and all fields stable until Ready. Dropping Valid before Ready cancels the request with no side effects.
- Writes produce no response. Read-after-write ordering between the ports is guaranteed by serialisation.
- Reset values: all outputs 0, state IDLE, last-grant pointer = 1. REQn_Ready is forced 0 while RST is high.
- RST asserted mid-operation returns the FSM to IDLE at that edge and drops RF strobes. A pending read response is discarded and no RSP pulse is issued.

## Timing
- Read: Ready at cycle T, RF_RdEn at T+1, RF_RdData valid at T+2, RSPn_Valid and RdData at T+3.
  - A new request can be accepted at T+3.
  - Throughput is 1 read per 3 cycles.
- Write: Ready at T, RF_WrEn at T+1, register updated at the end of T+1, next accept at T+2.
  - Throughput is 1 write per 2 cycles.
- A read response pulse and a new accept may coincide in the same IDLE cycle.
- At most one REQn_Ready is high per cycle. Ready is never high outside IDLE.

## Configuration
- REGFILE_ARB_ROUND_ROBIN_EN defined: round-robin arbitration.
  - When both ports are valid, the port not granted last wins.
  - The pointer updates on every grant.
  - After reset, port 0 wins the first contested cycle.
- Undefined: fixed priority, port 0 always wins. Port 1 is granted only when REQ0_Valid=0, and the pointer logic is removed.

## Test plan
- Reset then idle:
  - Outputs: all outputs 0, Busy=0, no Ready with both Valid low.
  - Mid-read reset: assert RST during RDWAIT. Expect IDLE next cycle and no RSP pulse.
- Single write/read:
  - Port 0 writes 16'hA5C3 to address 5; RF_WrEn=1 and RF_Address=5 at T+1.
  - Port 0 then reads address 5. Expect RSP0_Valid at T+3 with 16'hA5C3, and RSP1_Valid stays 0.
- Contention, round robin (macro defined): both ports hold read requests continuously.
  - Grants alternate 0,1,0,1.
  - Each RSP carries its own address's data, for example addr 2 = 16'h1111 and addr 6 = 16'h2222.
- Contention, fixed priority (macro undefined): same stimulus as the round-robin case.
  - Port 0 is granted every time.
  - Port 1 is granted only in the first IDLE cycle after REQ0_Valid drops.
- Cross-port ordering: port 1 writes 16'hBEEF to address 3 and port 0 then reads address 3. Expect RSP0_RdData=16'hBEEF.
- Withdrawn request: port 1 raises Valid during Busy, then drops it before IDLE. Expect no grant and no RF strobe for port 1.
